mul8_pipeline: RTL and testbench

Fully pipelined 8x8 unsigned multiplier that returns the high byte of the 16-bit product, i.e. (a_i*b_i)>>8.
- Accepts one operand pair per clock whenever valid_i is high.
- Has no backpressure.
- Used as a fixed-latency scaling/fractional-multiply datapath element. A valid flag travels alongside the data.

---
 rtl/mul8_pipeline.sv | 97 +++++++++
 tb/tb_mul8_pipeline.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul8_pipeline.sv
// mul8_pipeline: four-stage unsigned 8x8 multiplier returning the high byte
// of the 16-bit product. A valid bit travels alongside the data. Data
// registers load only when their incoming valid is set, so the output holds
// the last result while idle.
module mul8_pipeline (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o,
    output logic       valid_o
);

    // Stage 1 operand registers and per-stage valid bits
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic        v1_reg;
    logic        v2_reg;
    logic        v3_reg;

    // Shifted partial products formed from the stage-1 operands
    logic [15:0] pp [8];

    // Adder-tree registers
    logic [15:0] sum2_reg [4];
    logic [15:0] sum3_reg [2];

    // Partial product k is the multiplicand masked by bit k of the multiplier,
    // shifted into position k.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = {8'd0, a_reg & {8{b_reg[gi]}}} << gi;
        end
    endgenerate

    // Valid shift chain: each stage copies the previous one every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            v3_reg  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            v1_reg  <= valid_i;
            v2_reg  <= v1_reg;
            v3_reg  <= v2_reg;
            valid_o <= v3_reg;
        end
    end

    // Stage 1: capture the operand pair when it is marked valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= 8'd0;
            b_reg <= 8'd0;
        end else if (valid_i) begin
            a_reg <= a_i;
            b_reg <= b_i;
        end
    end

    // Stage 2: pairwise sums of the eight partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sum2_reg[i] <= 16'd0;
            end
        end else if (v1_reg) begin
            for (int i = 0; i < 4; i++) begin
                sum2_reg[i] <= pp[2*i] + pp[2*i+1];
            end
        end
    end

    // Stage 3: reduce four sums to two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum3_reg[0] <= 16'd0;
            sum3_reg[1] <= 16'd0;
        end else if (v2_reg) begin
            sum3_reg[0] <= sum2_reg[0] + sum2_reg[1];
            sum3_reg[1] <= sum2_reg[2] + sum2_reg[3];
        end
    end

    // Stage 4: final add; only the high byte of the product is kept
    // (truncation, no rounding).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_o <= 8'd0;
        end else if (v3_reg) begin
            p_o <= 8'((sum3_reg[0] + sum3_reg[1]) >> 8);
        end
    end

endmodule

// File: tb/tb_mul8_pipeline.sv
// tb_mul8_pipeline: directed and random-stream checks of mul8_pipeline.
`timescale 1ns/1ps
module tb_mul8_pipeline;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [7:0] p_o;
    logic       valid_o;

    int n_checks = 0;
    int n_errors = 0;

    mul8_pipeline dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .p_o     (p_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated pair: valid_o must stay low for the first three edges,
    // then rise with the expected high byte on the fourth.
    task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        tick();
        valid_i = 1'b0;
        a_i     = 8'd0;
        b_i     = 8'd0;
        tick();
        check({tag, " valid low e2"}, {15'd0, valid_o}, 16'd0);
        tick();
        check({tag, " valid low e3"}, {15'd0, valid_o}, 16'd0);
        tick();
        check({tag, " valid"}, {15'd0, valid_o}, 16'd1);
        check({tag, " p"}, {8'd0, p_o}, {8'd0, exp});
        tick();
        check({tag, " valid drop"}, {15'd0, valid_o}, 16'd0);
        check({tag, " p hold"}, {8'd0, p_o}, {8'd0, exp});
        $display("single a=0x%0h b=0x%0h -> p=0x%0h", a, b, p_o);
    endtask

    logic [7:0] burst_a   [3] = '{8'h55, 8'h55, 8'h65};
    logic [7:0] burst_b   [3] = '{8'h45, 8'h65, 8'h65};
    logic [7:0] burst_exp [3] = '{8'h16, 8'h21, 8'h27};
    logic [7:0] ext_a     [4] = '{8'hFF, 8'h00, 8'h80, 8'h0F};
    logic [7:0] ext_b     [4] = '{8'hFF, 8'hA7, 8'h02, 8'h10};
    logic [7:0] ext_exp   [4] = '{8'hFE, 8'h00, 8'h01, 8'h00};

    logic [7:0] sb_q [$];
    int         n_in;
    int         n_out;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [15:0] prod;
    int         density;

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        a_i     = 8'd0;
        b_i     = 8'd0;

        // 1. Outputs stay cleared while reset is held, even with valid input.
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            a_i     = 8'(i * 37 + 200);
            b_i     = 8'(i * 53 + 150);
            tick();
            check("reset valid_o", {15'd0, valid_o}, 16'd0);
            check("reset p_o", {8'd0, p_o}, 16'd0);
            $display("reset cycle %0d valid_o=%0b p_o=0x%0h", i, valid_o, p_o);
        end
        valid_i = 1'b0;
        a_i     = 8'd0;
        b_i     = 8'd0;
        #2 rst_n = 1'b1;
        tick();
        tick();

        // 2. Burst of three back-to-back pairs.
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            a_i     = burst_a[i];
            b_i     = burst_b[i];
            tick();
        end
        valid_i = 1'b0;
        a_i     = 8'd0;
        b_i     = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("burst valid", {15'd0, valid_o}, 16'd1);
            check("burst p", {8'd0, p_o}, {8'd0, burst_exp[i]});
            $display("burst %0d a=0x%0h b=0x%0h -> p=0x%0h", i, burst_a[i], burst_b[i], p_o);
        end

        // 3. Idle gap: p_o holds the last result.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle valid", {15'd0, valid_o}, 16'd0);
            check("idle p hold", {8'd0, p_o}, 16'h0027);
        end
        $display("idle gap of 10 cycles, p_o=0x%0h", p_o);
        run_single("gap single", 8'h45, 8'h45, 8'h12);

        // 4. Extremes.
        for (int i = 0; i < 4; i++) begin
            run_single("extreme", ext_a[i], ext_b[i], ext_exp[i]);
        end

        // 5. Random streaming against a scoreboard queue.
        n_in  = 0;
        n_out = 0;
        density = 2;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) density = $urandom_range(0, 4);
            ra = 8'($urandom);
            rb = 8'($urandom);
            valid_i = ($urandom_range(0, 3) < density) ? 1'b1 : 1'b0;
            a_i = ra;
            b_i = rb;
            if (valid_i) begin
                prod = 16'(ra) * 16'(rb);
                sb_q.push_back(prod[15:8]);
                n_in++;
            end
            tick();
            if (valid_o) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("stream unexpected valid", 16'd1, 16'd0);
                end else begin
                    check("stream p", {8'd0, p_o}, {8'd0, sb_q.pop_front()});
                end
            end
        end
        valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid_o) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("drain unexpected valid", 16'd1, 16'd0);
                end else begin
                    check("drain p", {8'd0, p_o}, {8'd0, sb_q.pop_front()});
                end
            end
        end
        check("stream count", 16'(n_out), 16'(n_in));
        check("stream queue empty", 16'(sb_q.size()), 16'd0);
        $display("stream: %0d pairs in, %0d results out", n_in, n_out);

        // 6. Reset with results in flight, asserted between clock edges.
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            a_i     = 8'hFF;
            b_i     = 8'hFF;
            tick();
        end
        valid_i = 1'b0;
        a_i     = 8'd0;
        b_i     = 8'd0;
        tick();
        check("pre-reset valid", {15'd0, valid_o}, 16'd1);
        check("pre-reset p", {8'd0, p_o}, 16'h00FE);
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid", {15'd0, valid_o}, 16'd0);
        check("async reset p", {8'd0, p_o}, 16'd0);
        $display("async reset mid-cycle: valid_o=%0b p_o=0x%0h", valid_o, p_o);
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post-reset no valid", {15'd0, valid_o}, 16'd0);
        end
        run_single("after reset", 8'h55, 8'h45, 8'h16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
